espectro_seq: RTL and testbench
===============================

ESPECTRO_SEQ -- requirements
Module: espectro_seq

Interface
REQ-001 Parameter PAT_W, default 49: pattern length in bits (2..64).
REQ-002 Parameter DIV_W, default 32: divider compare width.
REQ-003 Parameter PAT_INIT, default 49'b0101101111111111111101101010010000000000000100010: reset contents of active and shadow pattern registers.
REQ-004 clk50  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 enable  in  1  run gate; low pauses divider and index, forces sound low.
REQ-007 fr  in  DIV_W  half-period terminal count; bit period = 2*(fr+1) clk50 cycles.
REQ-008 pat_in  in  PAT_W  pattern data for load.
REQ-009 load  in  1  one-cycle strobe, writes pat_in to shadow register.
REQ-010 mode  in  1  0 = loop, 1 = one-shot; sampled on start.
REQ-011 start  in  1  one-cycle strobe, begins playback from the MSB.
REQ-012 stop  in  1  one-cycle strobe, aborts playback.
REQ-013 sound  out  1  registered serial pattern output.
REQ-014 busy  out  1  high while in RUN.
REQ-015 done  out  1  one-cycle pulse at one-shot completion.
REQ-016 bit_idx  out  clog2(PAT_W)  index of the bit currently played.

Function
REQ-017 The block SHALL use no derived clock; the divider produces a one-cycle step enable inside the clk50 domain.
REQ-018 FSM SHALL have two states: IDLE and RUN.
REQ-019 IDLE->RUN on start (stop low); on transition: active pattern <= shadow, bit_idx <= PAT_W-1, div_cnt <= 0, phase <= 0, mode latched.
REQ-020 RUN->IDLE on stop, or on a step at bit_idx==0 when latched mode=1 (one-shot).
REQ-021 In RUN with enable high, div_cnt SHALL increment each cycle; when div_cnt >= fr it SHALL clear to 0 and toggle phase.
REQ-022 A step SHALL occur on the cycle div_cnt >= fr with phase==1; a step decrements bit_idx.
REQ-023 The >= comparison SHALL prevent runaway when fr is lowered mid-run below div_cnt; fr=0 gives a 2-cycle bit period.
REQ-024 Step at bit_idx==0 in loop mode: bit_idx <= PAT_W-1 and active pattern <= shadow (new load takes effect only at wrap).
REQ-025 Step at bit_idx==0 in one-shot: return to IDLE, done=1 for exactly one cycle, bit_idx <= PAT_W-1.
REQ-026 With enable low in RUN: div_cnt, phase, bit_idx frozen; resumption with no lost or extra cycles.
REQ-027 sound SHALL be registered: next value = active[bit_idx] if (RUN and enable) else 0; one-cycle latency.
REQ-028 load SHALL write shadow in any state; active register is never written mid-pattern.
REQ-029 load and start in the same IDLE cycle: the new pat_in SHALL be played.
REQ-030 start and stop in the same cycle: stop wins, state IDLE.
REQ-031 start while in RUN SHALL be ignored.
REQ-032 busy SHALL be high exactly while state is RUN.

Reset
REQ-033 While rst is high at a clock edge: state IDLE, sound=0, busy=0, done=0, bit_idx=PAT_W-1, div_cnt=0, phase=0, active=shadow=PAT_INIT, latched mode=0.
REQ-034 rst SHALL take priority over all other inputs, including mid-run, and a start in the same cycle is discarded.

Verification
REQ-035 PAT_W=8, load 8'b10110001, fr=1, enable=1, mode=0, start -> sound sequence 1,0,1,1,0,0,0,1 each held 4 cycles, repeating, busy high.
REQ-036 Same, mode=1 -> one pass only, done pulses once at the final step, busy falls, sound 0 afterwards.
REQ-037 Loop running, load 8'hFF mid-pattern -> current pass completes unchanged, next pass all ones.
REQ-038 enable low for 10 cycles mid-bit -> sound 0 during pause, remaining bit time and sequence resume exactly.
REQ-039 fr changed from 100 to 3 while div_cnt=50 -> step on next cycle, subsequent bits 8 cycles each.
REQ-040 rst asserted mid-run with start in the same cycle -> all outputs reset values, IDLE, pattern back to PAT_INIT.

Source files
------------

// File: rtl/espectro_seq.sv
// Serial pattern sequencer: plays a shadow-loaded bit pattern MSB-first on `sound`,
// one bit per 2*(fr+1) clk50 cycles, looping or one-shot.
module espectro_seq #(
  parameter int PAT_W = 49,
  parameter int DIV_W = 32,
  parameter logic [PAT_W-1:0] PAT_INIT = 49'b0101101111111111111101101010010000000000000100010
) (
  input  logic                     clk50,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [DIV_W-1:0]         fr,
  input  logic [PAT_W-1:0]         pat_in,
  input  logic                     load,
  input  logic                     mode,
  input  logic                     start,
  input  logic                     stop,
  output logic                     sound,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(PAT_W)-1:0] bit_idx
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] active_pat, shadow_pat, shadow_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             phase;
  logic             mode_l;
  logic             div_hit, step, last_bit, go, finish;

  always_comb begin
    state_nxt  = state;
    div_hit    = (div_cnt >= fr);
    step       = (state == RUN) && enable && div_hit && phase;
    last_bit   = (bit_idx == '0);
    go         = (state == IDLE) && start && !stop;
    finish     = step && last_bit && mode_l;
    // A load in the same cycle as start/wrap must be what gets played.
    shadow_nxt = load ? pat_in : shadow_pat;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (stop || finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      shadow_pat <= PAT_INIT;
      active_pat <= PAT_INIT;
      bit_idx    <= IDX_MAX;
      div_cnt    <= '0;
      phase      <= 1'b0;
      mode_l     <= 1'b0;
      sound      <= 1'b0;
      done       <= 1'b0;
    end else begin
      shadow_pat <= shadow_nxt;
      sound      <= ((state == RUN) && enable) ? active_pat[bit_idx] : 1'b0;
      done       <= finish;
      if (go) begin
        active_pat <= shadow_nxt;
        bit_idx    <= IDX_MAX;
        div_cnt    <= '0;
        phase      <= 1'b0;
        mode_l     <= mode;
      end else if (state == RUN) begin
        if (stop) begin
          bit_idx <= IDX_MAX;
          div_cnt <= '0;
          phase   <= 1'b0;
        end else if (enable) begin
          // Second half-period terminal count is the bit step.
          if (div_hit) begin
            div_cnt <= '0;
            phase   <= ~phase;
            if (phase) begin
              if (last_bit) begin
                bit_idx <= IDX_MAX;
                if (!mode_l) active_pat <= shadow_nxt;
              end else begin
                bit_idx <= bit_idx - 1'b1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_espectro_seq.sv
// Directed bench for espectro_seq (PAT_W=8): table of playback scenarios plus
// hand-written sequences for pause, divider change, reset and strobe collisions.
module tb_espectro_seq;

  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk50 = 1'b0;
  logic          rst, enable, load, mode, start, stop;
  logic [DW-1:0] fr;
  logic [PW-1:0] pat_in;
  logic          sound, busy, done;
  logic [2:0]    bit_idx;

  int n_cmp = 0;
  int n_bad = 0;

  espectro_seq #(.PAT_W(PW), .DIV_W(DW), .PAT_INIT(8'hC3)) dut (
    .clk50(clk50), .rst(rst), .enable(enable), .fr(fr), .pat_in(pat_in),
    .load(load), .mode(mode), .start(start), .stop(stop),
    .sound(sound), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  always #5 clk50 = ~clk50;

  typedef struct {
    logic [7:0] pat;
    int         frv;
    logic       md;
    int         ml_k;
    logic [7:0] ml_val;
  } row_t;

  row_t rows[5];

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, got, want);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] p, input int per, input int k);
    return p[7 - ((k - 1) / per) % 8];
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int P, total, first, k2;
    logic [7:0] pp;
    logic es, eb, ed;
    int ei;

    rows[0] = '{8'b10110001, 1, 1'b0, 0,  8'h00};
    rows[1] = '{8'b10110001, 1, 1'b1, 0,  8'h00};
    rows[2] = '{8'b10110001, 1, 1'b0, 10, 8'hFF};
    rows[3] = '{8'b01011010, 0, 1'b0, 0,  8'h00};
    rows[4] = '{8'b11100100, 2, 1'b1, 0,  8'h00};

    rst = 1; enable = 1; load = 0; mode = 0; start = 0; stop = 0;
    fr = 16'd1; pat_in = '0;
    tick(); tick();
    chk("rst sound", sound, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst bit_idx", bit_idx, 7);
    rst = 0;

    // start and stop together: stop wins
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("start+stop busy", busy, 0);
    tick();
    chk("start+stop sound", sound, 0);

    // table scenarios (load together with start each time)
    for (int r = 0; r < 5; r++) begin
      P     = 2 * (rows[r].frv + 1);
      first = 8 * P;
      fr    = DW'(rows[r].frv);
      mode  = rows[r].md;
      pat_in = rows[r].pat;
      load  = 1; start = 1;
      tick();
      load = 0; start = 0; mode = ~mode;
      chk($sformatf("r%0d start busy", r), busy, 1);
      chk($sformatf("r%0d start sound", r), sound, 0);
      chk($sformatf("r%0d start idx", r), bit_idx, 7);
      total = rows[r].md ? first + 2 : 2 * first;
      for (int k = 1; k <= total; k++) begin
        if (k == rows[r].ml_k) begin
          load = 1; pat_in = rows[r].ml_val;
        end
        tick();
        load = 0;
        if (rows[r].md && k > first) begin
          es = 0; eb = 0; ed = 0; ei = 7;
        end else begin
          pp = (((k - 1) / first) > 0 && rows[r].ml_k != 0) ? rows[r].ml_val : rows[r].pat;
          es = pp[7 - ((k - 1) / P) % 8];
          eb = !(rows[r].md && k == first);
          ed = rows[r].md && (k == first);
          ei = (rows[r].md && k == first) ? 7 : 7 - ((k / P) % 8);
        end
        chk($sformatf("r%0d k%0d sound", r, k), sound, es);
        chk($sformatf("r%0d k%0d busy", r, k), busy, eb);
        chk($sformatf("r%0d k%0d done", r, k), done, ed);
        chk($sformatf("r%0d k%0d idx", r, k), bit_idx, ei);
      end
      if (!rows[r].md) begin
        stop = 1;
        tick();
        stop = 0;
        chk($sformatf("r%0d stop busy", r), busy, 0);
        tick();
        chk($sformatf("r%0d stop sound", r), sound, 0);
      end
      mode = 0;
    end

    // enable pause mid-bit, then a start while running (must be ignored)
    fr = 16'd1; mode = 0; pat_in = 8'b10110001; load = 1; start = 1;
    tick();
    load = 0; start = 0;
    repeat (6) tick();
    enable = 0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk($sformatf("pause%0d sound", j), sound, 0);
      chk($sformatf("pause%0d idx", j), bit_idx, 6);
      chk($sformatf("pause%0d busy", j), busy, 1);
    end
    enable = 1;
    for (int j = 1; j <= 40; j++) begin
      if (j == 10) begin
        start = 1; mode = 1;
      end
      tick();
      start = 0;
      k2 = 6 + j;
      chk($sformatf("resume%0d sound", j), sound, exp_bit(8'b10110001, 4, k2));
      chk($sformatf("resume%0d idx", j), bit_idx, 7 - ((k2 / 4) % 8));
      chk($sformatf("resume%0d busy", j), busy, 1);
    end
    mode = 0; stop = 1;
    tick();
    stop = 0;
    tick();

    // divider lowered below div_cnt during the stepping half-period
    fr = 16'd100; pat_in = 8'b10110001; load = 1; start = 1;
    tick();
    load = 0; start = 0;
    repeat (151) tick();
    chk("frchg pre idx", bit_idx, 7);
    fr = 16'd3;
    tick();
    chk("frchg step idx", bit_idx, 6);
    chk("frchg step sound", sound, 1);
    for (int t = 153; t <= 170; t++) begin
      tick();
      if (t == 153) chk("frchg t153 sound", sound, 0);
      if (t == 159) chk("frchg t159 idx", bit_idx, 6);
      if (t == 160) chk("frchg t160 idx", bit_idx, 5);
      if (t == 161) chk("frchg t161 sound", sound, 1);
      if (t == 167) chk("frchg t167 idx", bit_idx, 5);
      if (t == 168) chk("frchg t168 idx", bit_idx, 4);
    end
    stop = 1;
    tick();
    stop = 0;
    tick();

    // reset mid-run with start and load in the same cycle
    fr = 16'd1; pat_in = 8'h0F; load = 1; start = 1;
    tick();
    load = 0; start = 0;
    repeat (9) tick();
    rst = 1; start = 1; load = 1; pat_in = 8'hAA;
    tick();
    rst = 0; start = 0; load = 0;
    chk("rstrun busy", busy, 0);
    chk("rstrun sound", sound, 0);
    chk("rstrun done", done, 0);
    chk("rstrun idx", bit_idx, 7);
    tick();
    chk("rstrun busy2", busy, 0);
    fr = 16'd0; start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("init k%0d sound", k), sound, exp_bit(8'hC3, 2, k));
    end
    stop = 1;
    tick();
    stop = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
